sprite_layer_render: RTL

//  Parametrised sprite/overlay layer for the VGA pixel pipeline. Maps the scan position onto a movable

---
 rtl/vga_pkg.sv | 15 +
 rtl/sprite_addr_gen.sv | 35 +++
 rtl/sprite_layer_render.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and position types used by every layer of the pixel pipeline.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int POS_W = 10;
  localparam int DEF_PIX_W = 16;
  localparam logic [DEF_PIX_W-1:0] DEF_KEY_COLOUR = 16'hfff0;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    pos_t x;
    pos_t y;
  } point_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational window hit test and ROM address for one sprite layer.
// The hit test uses one extra bit, so a window reaching past column 1023 is clipped instead of wrapping.
module sprite_addr_gen
  import vga_pkg::*;
#(
  parameter int WIDTH  = 80,
  parameter int HEIGHT = 8,
  parameter int ADDR_W = 17,
  parameter int IDX_W  = 1
) (
  input  point_t            origin,
  input  logic [IDX_W-1:0]  frameIdx,
  input  pos_t              xPosition,
  input  pos_t              yPosition,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);
  localparam int FRAME_SIZE = WIDTH * HEIGHT;

  logic [POS_W:0]   xEnd, yEnd;
  logic [POS_W-1:0] dx, dy;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    xEnd = {1'b0, origin.x} + (POS_W + 1)'(WIDTH);
    yEnd = {1'b0, origin.y} + (POS_W + 1)'(HEIGHT);
    dx   = xPosition - origin.x;
    dy   = yPosition - origin.y;
    hit  = ({1'b0, xPosition} >= {1'b0, origin.x}) && ({1'b0, xPosition} < xEnd) &&
           ({1'b0, yPosition} >= {1'b0, origin.y}) && ({1'b0, yPosition} < yEnd);
    addr = '0;
    if (hit)
      addr = ADDR_W'(frameIdx) * ADDR_W'(FRAME_SIZE) + ADDR_W'(dy) * ADDR_W'(WIDTH) + ADDR_W'(dx);
  end
endmodule

// File: rtl/sprite_layer_render.sv
// Movable, animated sprite window for the VGA layer mixer: drives an external ROM address and returns
// the ROM pixel inside the window or the key colour outside it, ROM_LAT+2 clocks after the scan position.
module sprite_layer_render
  import vga_pkg::*;
#(
  parameter int X0         = 420,
  parameter int Y0         = 0,
  parameter int WIDTH      = 80,
  parameter int HEIGHT     = 8,
  parameter int FRAMES     = 1,
  parameter int FRAME_HOLD = 8,
  parameter int ADDR_W     = 17,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int ROM_LAT    = 1,
  parameter logic [PIX_W-1:0] KEY_COLOUR = PIX_W'(DEF_KEY_COLOUR)
) (
  input  logic              OriginalClk,
  input  logic              ResetN,
  input  logic [POS_W-1:0]  XPosition,
  input  logic [POS_W-1:0]  YPosition,
  input  logic              FrameStart,
  input  logic              PosLoad,
  input  logic [POS_W-1:0]  NewX,
  input  logic [POS_W-1:0]  NewY,
  input  logic              AnimEnable,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [PIX_W-1:0]  RomData,
  output logic [PIX_W-1:0]  LayerOutput,
  output logic              LayerHit
);
  localparam int IDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  point_t             origin, pending;
  logic               pendValid;
  logic [IDX_W-1:0]   frameIdx;
  logic [HOLD_W-1:0]  holdCnt;
  logic               addrHit;
  logic [ADDR_W-1:0]  addrNext;
  logic [ROM_LAT:0]   hitPipe;

  sprite_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_addr_gen (
    .origin    (origin),
    .frameIdx  (frameIdx),
    .xPosition (XPosition),
    .yPosition (YPosition),
    .hit       (addrHit),
    .addr      (addrNext)
  );

  // Origin only moves at FrameStart; a load in the same cycle bypasses the pending slot.
  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge OriginalClk or negedge ResetN) begin
    if (!ResetN) begin
      origin    <= '{x: POS_W'(X0), y: POS_W'(Y0)};
      pending   <= '0;
      pendValid <= 1'b0;
    end else if (FrameStart) begin
      if (PosLoad)        origin <= '{x: NewX, y: NewY};
      else if (pendValid) origin <= pending;
      pendValid <= 1'b0;
    end else if (PosLoad) begin
      pending   <= '{x: NewX, y: NewY};
      pendValid <= 1'b1;
    end
  end

  always_ff @(posedge OriginalClk or negedge ResetN) begin
    if (!ResetN) begin
      frameIdx <= '0;
      holdCnt  <= '0;
    end else if (FrameStart && AnimEnable) begin
      if (holdCnt == HOLD_W'(FRAME_HOLD - 1)) begin
        holdCnt  <= '0;
        frameIdx <= (frameIdx == IDX_W'(FRAMES - 1)) ? '0 : frameIdx + IDX_W'(1);
      end else begin
        holdCnt <= holdCnt + HOLD_W'(1);
      end
    end
  end

  // hitPipe[0] pairs with RomAddr; hitPipe[ROM_LAT] pairs with the returned RomData.
  // NOTE: the hit pipe is reset so in-flight pixels vanish on reset; the ROM contents never need one.
  always_ff @(posedge OriginalClk or negedge ResetN) begin
    if (!ResetN) begin
      RomAddr     <= '0;
      hitPipe     <= '0;
      LayerHit    <= 1'b0;
      LayerOutput <= KEY_COLOUR;
    end else begin
      RomAddr     <= addrNext;
      hitPipe     <= {hitPipe[ROM_LAT-1:0], addrHit};
      LayerHit    <= hitPipe[ROM_LAT];
      LayerOutput <= hitPipe[ROM_LAT] ? RomData : KEY_COLOUR;
    end
  end
endmodule
